// File: rtl/mem_loader_if.sv
// Byte-stream input and flash write port of the program loader.
// The master side feeds bytes and observes writes; the loader is the slave.
interface mem_loader_if #(
   parameter int unsigned WIDTH = 32
);
   logic [7:0]       in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] flash_addr;
   logic [WIDTH-1:0] flash_data;
   logic             flash_en;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  flash_addr,
      input  flash_data,
      input  flash_en
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output flash_addr,
      output flash_data,
      output flash_en
   );
endinterface

// File: rtl/mem_loader.sv
// Streaming program loader: deframes a length-prefixed, checksummed byte packet
// into single-cycle flash word writes and releases the CPU only after a clean load.
module mem_loader #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] BASE_ADDR = '0,
   parameter int unsigned      MAX_WORDS = 512
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   mem_loader_if.slave  bus,
   output logic         cpu_rst,
   output logic         busy,
   output logic         done,
   output logic         err
);

   localparam int unsigned BPW = WIDTH / 8;
   localparam int unsigned BIW = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int unsigned CW  = $clog2(MAX_WORDS + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_WRITE,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [BIW-1:0]   byte_idx_q;
   logic [CW-1:0]    word_idx_q;
   logic [CW-1:0]    count_q;
   logic [7:0]       sum_q;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] flash_addr_q;
   logic [WIDTH-1:0] flash_data_q;

   logic             accept;
   logic             last_byte;
   logic             idle_like;
   logic [WIDTH-1:0] word_next;
   logic [7:0]       sum_next;
   logic [CW-1:0]    word_idx_inc;

   assign accept       = bus.in_valid && bus.in_ready;
   assign last_byte    = (byte_idx_q == BIW'(BPW - 1));
   assign idle_like    = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
   // Little-endian assembly: each new byte enters at the top and shifts down,
   // so after BPW bytes the first byte received sits in bits [7:0].
   assign word_next    = {bus.in_data, shift_q[WIDTH-1:8]};
   assign sum_next     = sum_q + bus.in_data;
   assign word_idx_inc = word_idx_q + CW'(1);

   assign bus.flash_addr = flash_addr_q;
   assign bus.flash_data = flash_data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      bus.in_ready = 1'b0;
      bus.flash_en = 1'b0;
      busy         = 1'b1;
      done         = 1'b0;
      err          = 1'b0;
      cpu_rst      = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_d = S_LEN;
         end
         S_DONE: begin
            busy    = 1'b0;
            done    = 1'b1;
            cpu_rst = 1'b0;
            if (start) state_d = S_LEN;
         end
         S_ERR: begin
            busy = 1'b0;
            err  = 1'b1;
            if (start) state_d = S_LEN;
         end
         S_LEN: begin
            bus.in_ready = 1'b1;
            if (accept && last_byte) begin
               if (word_next == '0) begin
                  state_d = S_CSUM;
               end else if (word_next > WIDTH'(MAX_WORDS)) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            bus.in_ready = 1'b1;
            if (accept && last_byte) state_d = S_WRITE;
         end
         S_WRITE: begin
            bus.flash_en = 1'b1;
            state_d      = (word_idx_inc == count_q) ? S_CSUM : S_DATA;
         end
         S_CSUM: begin
            bus.in_ready = 1'b1;
            if (accept) state_d = (sum_next == 8'h00) ? S_DONE : S_ERR;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_idx_q   <= '0;
         word_idx_q   <= '0;
         count_q      <= '0;
         sum_q        <= '0;
         shift_q      <= '0;
         flash_addr_q <= '0;
         flash_data_q <= '0;
      end else begin
         if (idle_like && start) begin
            byte_idx_q <= '0;
            word_idx_q <= '0;
            count_q    <= '0;
            sum_q      <= '0;
         end
         if (accept) begin
            shift_q    <= word_next;
            sum_q      <= sum_next;
            byte_idx_q <= last_byte ? '0 : byte_idx_q + BIW'(1);
            if (state_q == S_LEN && last_byte) begin
               count_q <= CW'(word_next);
            end
            // Address and data are latched here so they change together with
            // the write strobe and then hold until the next word.
            if (state_q == S_DATA && last_byte) begin
               flash_data_q <= word_next;
               flash_addr_q <= BASE_ADDR + WIDTH'(word_idx_q) * WIDTH'(BPW);
            end
         end
         if (state_q == S_WRITE) begin
            word_idx_q <= word_idx_inc;
         end
      end
   end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: table of packets with expected writes and
// final status, plus a hand-written mid-load reset sequence.
module tb_mem_loader;

   logic clk;
   logic rst;
   logic start;
   logic cpu_rst;
   logic busy;
   logic done;
   logic err;

   mem_loader_if #(.WIDTH(32)) bus ();

   mem_loader #(
      .WIDTH     (32),
      .BASE_ADDR (32'h0),
      .MAX_WORDS (512)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bus     (bus),
      .cpu_rst (cpu_rst),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [0:23][7:0] bytes;
      logic [7:0]       nbytes;
      logic [2:0]       nwr;
      logic [0:3][31:0] addr;
      logic [0:3][31:0] data;
      logic             exp_done;
      logic [1:0]       gap;
      logic             poke;
   } vec_t;

   vec_t vecs[6];

   int total = 0;
   int bad   = 0;

   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Capture every write strobe and confirm the stream is stalled during it.
   always @(negedge clk) begin
      if (bus.flash_en === 1'b1) begin
         wr_addr.push_back(bus.flash_addr);
         wr_data.push_back(bus.flash_data);
         chk("ready_during_write", 64'(bus.in_ready), 64'd0);
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_max, input bit poke);
      int g;
      int n;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int i = 0; i < g; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.in_data  = 8'($urandom);
         start        = poke;
      end
      @(negedge clk);
      start        = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got in_ready=0 for 50 cycles expected 1");
      end
      @(posedge clk);
   endtask

   task automatic run_row(input vec_t v, input string tag);
      wr_addr.delete();
      wr_data.delete();
      pulse_start();
      chk({tag, ".busy_start"}, 64'(busy), 64'd1);
      chk({tag, ".cpu_rst_start"}, 64'(cpu_rst), 64'd1);
      chk({tag, ".done_clr"}, 64'(done), 64'd0);
      chk({tag, ".err_clr"}, 64'(err), 64'd0);
      for (int i = 0; i < int'(v.nbytes); i++) begin
         send_byte(v.bytes[i], int'(v.gap), v.poke);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk({tag, ".done"}, 64'(done), 64'(v.exp_done));
      chk({tag, ".err"}, 64'(err), 64'(!v.exp_done));
      chk({tag, ".cpu_rst"}, 64'(cpu_rst), 64'(!v.exp_done));
      chk({tag, ".busy_end"}, 64'(busy), 64'd0);
      chk({tag, ".ready_end"}, 64'(bus.in_ready), 64'd0);
      repeat (3) @(negedge clk);
      chk({tag, ".nwrites"}, 64'(wr_addr.size()), 64'(v.nwr));
      for (int i = 0; i < int'(v.nwr); i++) begin
         if (i < wr_addr.size()) begin
            chk($sformatf("%s.addr%0d", tag, i), 64'(wr_addr[i]), 64'(v.addr[i]));
            chk($sformatf("%s.data%0d", tag, i), 64'(wr_data[i]), 64'(v.data[i]));
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 6; k++) vecs[k] = '0;

      vecs[0].bytes[0:20] = {8'h04, 8'h00, 8'h00, 8'h00,
                             8'h16, 8'h00, 8'hEF, 8'hBE, 8'h20, 8'h00, 8'hEF, 8'hBE,
                             8'h24, 8'h00, 8'hEF, 8'hBE, 8'h28, 8'h00, 8'hEF, 8'hBE,
                             8'hC6};
      vecs[0].nbytes   = 8'd21;
      vecs[0].nwr      = 3'd4;
      vecs[0].addr     = {32'h0, 32'h4, 32'h8, 32'hC};
      vecs[0].data     = {32'hBEEF0016, 32'hBEEF0020, 32'hBEEF0024, 32'hBEEF0028};
      vecs[0].exp_done = 1'b1;

      vecs[1]          = vecs[0];
      vecs[1].bytes[20] = 8'hC7;
      vecs[1].exp_done = 1'b0;

      vecs[2].bytes[0:4] = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[2].nbytes     = 8'd5;
      vecs[2].exp_done   = 1'b1;

      vecs[3].bytes[0:3] = {8'h01, 8'h02, 8'h00, 8'h00};
      vecs[3].nbytes     = 8'd4;
      vecs[3].exp_done   = 1'b0;

      vecs[4]      = vecs[0];
      vecs[4].gap  = 2'd3;
      vecs[4].poke = 1'b1;

      vecs[5].bytes[0:8] = {8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEB};
      vecs[5].nbytes     = 8'd9;
      vecs[5].nwr        = 3'd1;
      vecs[5].addr[0]    = 32'h0;
      vecs[5].data[0]    = 32'h12345678;
      vecs[5].exp_done   = 1'b1;

      rst          = 1'b1;
      start        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst.in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst.flash_en", 64'(bus.flash_en), 64'd0);
      chk("rst.flash_addr", 64'(bus.flash_addr), 64'd0);
      chk("rst.flash_data", 64'(bus.flash_data), 64'd0);
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.done", 64'(done), 64'd0);
      chk("rst.err", 64'(err), 64'd0);
      chk("rst.cpu_rst", 64'(cpu_rst), 64'd1);
      rst = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 6; k++) begin
         run_row(vecs[k], $sformatf("row%0d", k));
      end

      // Reset in the middle of the second word: one write issued, then abort.
      wr_addr.delete();
      wr_data.delete();
      pulse_start();
      for (int i = 0; i < 10; i++) begin
         send_byte(vecs[0].bytes[i], 0, 1'b0);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("abort.flash_en", 64'(bus.flash_en), 64'd0);
      chk("abort.busy", 64'(busy), 64'd0);
      chk("abort.cpu_rst", 64'(cpu_rst), 64'd1);
      chk("abort.in_ready", 64'(bus.in_ready), 64'd0);
      repeat (3) @(negedge clk);
      chk("abort.nwrites", 64'(wr_addr.size()), 64'd1);
      if (wr_data.size() > 0) begin
         chk("abort.data0", 64'(wr_data[0]), 64'h00000000BEEF0016);
      end
      rst = 1'b0;
      @(negedge clk);
      run_row(vecs[0], "after_abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
